// File: rtl/floor_request_reg.sv
// Elevator button request register: per-channel synchroniser, optional debounce (BTN_DEBOUNCE_EN),
// rising-edge detect and request latch, plus direction summaries and a pending-request count.
module floor_request_reg #(
    parameter int FLOORS          = 8,
    parameter int FW              = $clog2(FLOORS),
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CW              = $clog2(3*FLOORS-1)
) (
    input  logic              clock,
    input  logic              an_reset,
    input  logic              buttons_block,
    input  logic [FLOORS-1:0] btn_in,
    input  logic [FLOORS-2:0] btn_up_out,
    input  logic [FLOORS-1:1] btn_down_out,
    input  logic [FLOORS-1:0] inactivate_in_levels,
    input  logic [FLOORS-2:0] inactivate_out_up_levels,
    input  logic [FLOORS-1:1] inactivate_out_down_levels,
    input  logic [FW-1:0]     current_floor,
    output logic [FLOORS-1:0] active_in_levels,
    output logic [FLOORS-2:0] active_out_up_levels,
    output logic [FLOORS-1:1] active_out_down_levels,
    output logic              any_above,
    output logic              any_below,
    output logic              any_here,
    output logic [CW-1:0]     pending_count
);
    // Channel layout: [FLOORS-1:0] cabin, then up buttons of floors 0..FLOORS-2, then down of 1..FLOORS-1.
    localparam int NCH = 3*FLOORS-2;

    logic [NCH-1:0] w_btn;
    logic [NCH-1:0] w_clr;
    logic [NCH-1:0] w_clean;
    logic [NCH-1:0] w_press;
    logic [NCH-1:0] w_active_next;
    logic [NCH-1:0] r_s1;
    logic [NCH-1:0] r_s2;
    logic [NCH-1:0] r_clean_d;
    logic [NCH-1:0] r_active;
    logic [FLOORS-1:0] w_req;
    logic [CW-1:0]  w_count;

    assign w_btn = {btn_down_out, btn_up_out, btn_in};
    assign w_clr = {inactivate_out_down_levels, inactivate_out_up_levels, inactivate_in_levels};

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
        end
    endgenerate

`ifdef BTN_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES+1);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_debounce
            logic [DBW-1:0] r_cnt;
            logic           r_clean;

            always_ff @(posedge clock or negedge an_reset) begin
                if (!an_reset) begin
                    r_cnt   <= '0;
                    r_clean <= 1'b0;
                end else if (r_s2[gi] == r_clean) begin
                    r_cnt <= '0;
                end else if (r_cnt == DBW'(DEBOUNCE_CYCLES-1)) begin
                    r_clean <= r_s2[gi];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + DBW'(1);
                end
            end

            assign w_clean[gi] = r_clean;
        end
    endgenerate
`else
    assign w_clean = r_s2;
`endif

    // A clear beats a simultaneous press; a press in a blocked cycle is simply dropped.
    assign w_press       = w_clean & ~r_clean_d;
    assign w_active_next = ~w_clr & (r_active | (w_press & {NCH{~buttons_block}}));

    always_ff @(posedge clock or negedge an_reset) begin
        if (!an_reset) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_clean_d <= '0;
            r_active  <= '0;
        end else begin
            r_s1      <= w_btn;
            r_s2      <= r_s1;
            r_clean_d <= w_clean;
            r_active  <= w_active_next;
        end
    end

    assign active_in_levels       = r_active[FLOORS-1:0];
    assign active_out_up_levels   = r_active[2*FLOORS-2:FLOORS];
    assign active_out_down_levels = r_active[3*FLOORS-3:2*FLOORS-1];

    generate
        for (genvar gi = 0; gi < FLOORS; gi++) begin : g_req
            if (gi == 0) begin : g_bottom
                assign w_req[gi] = r_active[gi] | r_active[FLOORS+gi];
            end else if (gi == FLOORS-1) begin : g_top
                assign w_req[gi] = r_active[gi] | r_active[2*FLOORS-2+gi];
            end else begin : g_mid
                assign w_req[gi] = r_active[gi] | r_active[FLOORS+gi] | r_active[2*FLOORS-2+gi];
            end
        end
    endgenerate

    // An out-of-range floor naturally puts every request below it.
    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        any_here  = 1'b0;
        for (int f = 0; f < FLOORS; f++) begin
            if (f < int'(current_floor)) begin
                any_below = any_below | w_req[f];
            end else if (f == int'(current_floor)) begin
                any_here = any_here | w_req[f];
            end else begin
                any_above = any_above | w_req[f];
            end
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < NCH; i++) begin
            w_count = w_count + CW'(r_active[i]);
        end
    end

    assign pending_count = w_count;

endmodule

// File: tb/tb_floor_request_reg.sv
// Directed bench for floor_request_reg: main instance FLOORS=8 (FW=4 so out-of-range floors can be driven),
// plus FLOORS=2 and FLOORS=16 instances for the single-press parametrisation check.
module tb_floor_request_reg;
`ifdef BTN_DEBOUNCE_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic blk;
    logic [7:0] b_in;
    logic [6:0] b_up;
    logic [7:1] b_dn;
    logic [7:0] c_in;
    logic [6:0] c_up;
    logic [7:1] c_dn;
    logic [3:0] cf;
    logic [7:0] a_in;
    logic [6:0] a_up;
    logic [7:1] a_dn;
    logic above, below, here;
    logic [4:0] pend;

    logic [1:0] b2_in, c2_in, a2_in;
    logic [0:0] b2_up, c2_up, a2_up, cf2;
    logic [1:1] b2_dn, c2_dn, a2_dn;
    logic above2, below2, here2;
    logic [2:0] pend2;

    logic [15:0] b16_in, c16_in, a16_in;
    logic [14:0] b16_up, c16_up, a16_up;
    logic [15:1] b16_dn, c16_dn, a16_dn;
    logic [3:0] cf16;
    logic above16, below16, here16;
    logic [5:0] pend16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    floor_request_reg #(.FLOORS(8), .FW(4)) dut (
        .clock(clk), .an_reset(rst_n), .buttons_block(blk),
        .btn_in(b_in), .btn_up_out(b_up), .btn_down_out(b_dn),
        .inactivate_in_levels(c_in), .inactivate_out_up_levels(c_up), .inactivate_out_down_levels(c_dn),
        .current_floor(cf),
        .active_in_levels(a_in), .active_out_up_levels(a_up), .active_out_down_levels(a_dn),
        .any_above(above), .any_below(below), .any_here(here), .pending_count(pend)
    );

    floor_request_reg #(.FLOORS(2)) dut2 (
        .clock(clk), .an_reset(rst_n), .buttons_block(blk),
        .btn_in(b2_in), .btn_up_out(b2_up), .btn_down_out(b2_dn),
        .inactivate_in_levels(c2_in), .inactivate_out_up_levels(c2_up), .inactivate_out_down_levels(c2_dn),
        .current_floor(cf2),
        .active_in_levels(a2_in), .active_out_up_levels(a2_up), .active_out_down_levels(a2_dn),
        .any_above(above2), .any_below(below2), .any_here(here2), .pending_count(pend2)
    );

    floor_request_reg #(.FLOORS(16)) dut16 (
        .clock(clk), .an_reset(rst_n), .buttons_block(blk),
        .btn_in(b16_in), .btn_up_out(b16_up), .btn_down_out(b16_dn),
        .inactivate_in_levels(c16_in), .inactivate_out_up_levels(c16_up), .inactivate_out_down_levels(c16_dn),
        .current_floor(cf16),
        .active_in_levels(a16_in), .active_out_up_levels(a16_up), .active_out_down_levels(a16_dn),
        .any_above(above16), .any_below(below16), .any_here(here16), .pending_count(pend16)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({a_in, a_up, a_dn} !== 22'h0) begin
            failures++;
            $display("FAIL reset_active got=%h exp=0", {a_in, a_up, a_dn});
        end
        checks++;
        if ({above, below, here, pend} !== 8'h0) begin
            failures++;
            $display("FAIL reset_summary got=%b exp=0", {above, below, here, pend});
        end
        tick(2);
        rst_n = 1'b1;
        tick(2);
        $display("test_reset done");
    endtask

    task automatic test_single_press;
        cf = 4'd0;
        b_in[3] = 1'b1;
        tick(LAT-1);
        checks++;
        if (a_in !== 8'h00) begin
            failures++;
            $display("FAIL single_early got=%h exp=00", a_in);
        end
        tick(1);
        checks++;
        if (a_in !== 8'h08) begin
            failures++;
            $display("FAIL single_latch got=%h exp=08", a_in);
        end
        checks++;
        if (pend !== 5'd1) begin
            failures++;
            $display("FAIL single_count got=%0d exp=1", pend);
        end
        checks++;
        if ({above, below, here} !== 3'b100) begin
            failures++;
            $display("FAIL single_dirs got=%b exp=100", {above, below, here});
        end
        tick(10 - LAT);
        b_in[3] = 1'b0;
        c_in[3] = 1'b1;
        tick(1);
        c_in[3] = 1'b0;
        checks++;
        if (a_in !== 8'h00) begin
            failures++;
            $display("FAIL single_clear got=%h exp=00", a_in);
        end
        tick(LAT+2);
        $display("test_single_press done");
    endtask

    task automatic test_clear_held;
        b_up[2] = 1'b1;
        tick(LAT);
        checks++;
        if (a_up !== 7'h04) begin
            failures++;
            $display("FAIL held_latch got=%h exp=04", a_up);
        end
        c_up[2] = 1'b1;
        tick(1);
        c_up[2] = 1'b0;
        checks++;
        if (a_up !== 7'h00) begin
            failures++;
            $display("FAIL held_clear got=%h exp=00", a_up);
        end
        tick(5);
        checks++;
        if (a_up !== 7'h00) begin
            failures++;
            $display("FAIL held_no_relatch got=%h exp=00", a_up);
        end
        b_up[2] = 1'b0;
        tick(LAT+2);
        b_up[2] = 1'b1;
        tick(LAT);
        checks++;
        if (a_up !== 7'h04) begin
            failures++;
            $display("FAIL held_repress got=%h exp=04", a_up);
        end
        b_up[2] = 1'b0;
        c_up[2] = 1'b1;
        tick(1);
        c_up[2] = 1'b0;
        tick(LAT+2);
        $display("test_clear_held done");
    endtask

    task automatic test_clear_priority;
        b_dn[5] = 1'b1;
        tick(LAT-1);
        c_dn[5] = 1'b1;
        tick(1);
        c_dn[5] = 1'b0;
        checks++;
        if (a_dn !== 7'h00) begin
            failures++;
            $display("FAIL prio_same_cycle got=%h exp=00", a_dn);
        end
        tick(4);
        checks++;
        if (pend !== 5'd0) begin
            failures++;
            $display("FAIL prio_press_lost got=%0d exp=0", pend);
        end
        b_dn[5] = 1'b0;
        tick(LAT+2);
        $display("test_clear_priority done");
    endtask

    task automatic test_blocking;
        b_in[6] = 1'b1;
        tick(LAT);
        b_in[6] = 1'b0;
        checks++;
        if (a_in !== 8'h40) begin
            failures++;
            $display("FAIL block_setup got=%h exp=40", a_in);
        end
        blk = 1'b1;
        b_in[1] = 1'b1;
        c_in[6] = 1'b1;
        tick(1);
        c_in[6] = 1'b0;
        tick(LAT+1);
        checks++;
        if (a_in !== 8'h00) begin
            failures++;
            $display("FAIL block_press got=%h exp=00", a_in);
        end
        blk = 1'b0;
        tick(3);
        checks++;
        if (a_in !== 8'h00) begin
            failures++;
            $display("FAIL block_not_deferred got=%h exp=00", a_in);
        end
        b_in[1] = 1'b0;
        tick(LAT+2);
        $display("test_blocking done");
    endtask

    task automatic test_summaries;
        logic [7:0] mask;
        logic eb, eh, ea;
        mask = 8'b1001_0010;
        b_in[1] = 1'b1;
        b_up[4] = 1'b1;
        b_dn[7] = 1'b1;
        tick(LAT);
        b_in[1] = 1'b0;
        b_up[4] = 1'b0;
        b_dn[7] = 1'b0;
        checks++;
        if ({a_in, a_up, a_dn} !== {8'h02, 7'h10, 7'h40}) begin
            failures++;
            $display("FAIL sum_latch got=%h/%h/%h exp=02/10/40", a_in, a_up, a_dn);
        end
        checks++;
        if (pend !== 5'd3) begin
            failures++;
            $display("FAIL sum_count got=%0d exp=3", pend);
        end
        for (int c = 0; c < 8; c++) begin
            cf = 4'(c);
            #1;
            eb = 1'b0;
            eh = mask[c];
            ea = 1'b0;
            for (int f = 0; f < c; f++) eb = eb | mask[f];
            for (int f = c + 1; f < 8; f++) ea = ea | mask[f];
            checks++;
            if ({below, here, above} !== {eb, eh, ea}) begin
                failures++;
                $display("FAIL sum_sweep cf=%0d got=%b exp=%b", c, {below, here, above}, {eb, eh, ea});
            end
        end
        cf = 4'd9;
        #1;
        checks++;
        if ({below, here, above} !== 3'b100) begin
            failures++;
            $display("FAIL sum_out_of_range got=%b exp=100", {below, here, above});
        end
        cf = 4'd0;
        c_in[1] = 1'b1;
        c_up[4] = 1'b1;
        c_dn[7] = 1'b1;
        tick(1);
        c_in[1] = 1'b0;
        c_up[4] = 1'b0;
        c_dn[7] = 1'b0;
        checks++;
        if (pend !== 5'd0) begin
            failures++;
            $display("FAIL sum_cleared got=%0d exp=0", pend);
        end
        tick(LAT+2);
        $display("test_summaries done");
    endtask

`ifdef BTN_DEBOUNCE_EN
    task automatic test_debounce;
        b_in[0] = 1'b1;
        tick(2);
        b_in[0] = 1'b0;
        tick(10);
        checks++;
        if (a_in !== 8'h00) begin
            failures++;
            $display("FAIL debounce_glitch got=%h exp=00", a_in);
        end
        b_in[0] = 1'b1;
        tick(6);
        checks++;
        if (a_in !== 8'h00) begin
            failures++;
            $display("FAIL debounce_e5 got=%h exp=00", a_in);
        end
        b_in[0] = 1'b0;
        tick(1);
        checks++;
        if (a_in !== 8'h01) begin
            failures++;
            $display("FAIL debounce_e6 got=%h exp=01", a_in);
        end
        c_in[0] = 1'b1;
        tick(1);
        c_in[0] = 1'b0;
        tick(LAT+2);
        $display("test_debounce done");
    endtask
`endif

    task automatic test_async_reset;
        cf = 4'd0;
        b_in[0] = 1'b1;
        b_in[2] = 1'b1;
        b_up[3] = 1'b1;
        b_dn[6] = 1'b1;
        b_in[7] = 1'b1;
        tick(LAT);
        b_in = '0;
        b_up = '0;
        b_dn = '0;
        checks++;
        if ({pend, here} !== {5'd5, 1'b1}) begin
            failures++;
            $display("FAIL areset_setup got=%0d/%b exp=5/1", pend, here);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_in, a_up, a_dn} !== 22'h0) begin
            failures++;
            $display("FAIL areset_active got=%h exp=0", {a_in, a_up, a_dn});
        end
        checks++;
        if ({above, below, here, pend} !== 8'h0) begin
            failures++;
            $display("FAIL areset_summary got=%b exp=0", {above, below, here, pend});
        end
        tick(1);
        rst_n = 1'b1;
        tick(LAT+2);
        $display("test_async_reset done");
    endtask

    task automatic test_params;
        cf2 = 1'b0;
        cf16 = 4'd0;
        b2_in[1] = 1'b1;
        b16_in[3] = 1'b1;
        tick(LAT-1);
        checks++;
        if ({a2_in, a16_in} !== 18'h0) begin
            failures++;
            $display("FAIL param_early got=%h/%h exp=0/0", a2_in, a16_in);
        end
        tick(1);
        checks++;
        if ({a2_in, pend2, above2, below2, here2} !== {2'b10, 3'd1, 3'b100}) begin
            failures++;
            $display("FAIL param_f2 got=%b/%0d/%b exp=10/1/100", a2_in, pend2, {above2, below2, here2});
        end
        checks++;
        if ({a16_in, pend16, above16, below16, here16} !== {16'h0008, 6'd1, 3'b100}) begin
            failures++;
            $display("FAIL param_f16 got=%h/%0d/%b exp=0008/1/100", a16_in, pend16, {above16, below16, here16});
        end
        b2_in[1] = 1'b0;
        b16_in[3] = 1'b0;
        tick(2);
        $display("test_params done");
    endtask

    initial begin
        rst_n = 1'b0;
        blk = 1'b0;
        cf = '0;
        {b_in, b_up, b_dn, c_in, c_up, c_dn} = '0;
        {b2_in, b2_up, b2_dn, c2_in, c2_up, c2_dn, cf2} = '0;
        {b16_in, b16_up, b16_dn, c16_in, c16_up, c16_dn, cf16} = '0;
        tick(1);
        test_reset;
        test_single_press;
        test_clear_held;
        test_clear_priority;
        test_blocking;
        test_summaries;
`ifdef BTN_DEBOUNCE_EN
        test_debounce;
`endif
        test_async_reset;
        test_params;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
